// File: rtl/mod_exp_pkg.sv
// Shared types and helpers for the mod_exp modular exponentiation engine.
// bit_len is only needed by the MOD_EXP_SKIP_LEAD_EN build.
package mod_exp_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int PROD_WIDTH = 2 * DEF_WIDTH;

  typedef enum logic [2:0] {IDLE, LOAD, SQ, MUL, DONE} state_t;

  // Number of significant bits in v (0 for v==0); MSB index is bit_len-1.
  function automatic int bit_len(input logic [63:0] v);
    int len;
    len = 0;
    for (int j = 0; j < 64; j++) begin
      if (v[j]) len = j + 1;
    end
    return len;
  endfunction

endpackage

// File: rtl/mod_exp_mod.sv
// Combinational modulo reducer. A zero divisor yields 0 so downstream logic
// never sees an undefined value.
module mod
  import mod_exp_pkg::*;
#(
  parameter int WIDTH = PROD_WIDTH
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remainder
);

  assign remainder = (divisor == '0) ? '0 : (dividend % divisor);

endmodule

// File: rtl/mod_exp.sv
// Left-to-right square-and-multiply modular exponentiation, one reduction per cycle.
// Optional MOD_EXP_SKIP_LEAD_EN skips squarings for the exponent's leading zeros.
module mod_exp
  import mod_exp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Base,
  input  logic [WIDTH-1:0] Exponent,
  input  logic [WIDTH-1:0] Modulus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] Result
);

  localparam int PW = 2 * WIDTH;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] b_r, e_r, n_r, acc;
  logic [IW-1:0]    idx;

  logic [PW-1:0]    dividend, rem;
  logic [WIDTH-1:0] rem_w, one_mod;
  logic             unused_rem_hi;

  // Operands are zero-extended before multiplying so nothing is lost pre-reduction.
  always_comb begin
    dividend = '0;
    case (state)
      LOAD:    dividend = {{WIDTH{1'b0}}, b_r};
      SQ:      dividend = PW'(acc) * PW'(acc);
      MUL:     dividend = PW'(acc) * PW'(b_r);
      default: dividend = '0;
    endcase
  end

  mod #(.WIDTH(PW)) u_mod (
    .dividend (dividend),
    .divisor  ({{WIDTH{1'b0}}, n_r}),
    .remainder(rem)
  );

  // Remainder is below n_r, so the upper half is always zero.
  assign rem_w         = rem[WIDTH-1:0];
  assign unused_rem_hi = ^rem[PW-1:WIDTH];
  assign one_mod       = (n_r == WIDTH'(1)) ? '0 : WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      b_r    <= '0;
      e_r    <= '0;
      n_r    <= '0;
      acc    <= '0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      Result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            b_r   <= Base;
            e_r   <= Exponent;
            n_r   <= Modulus;
            err   <= 1'b0;
            idx   <= IW'(WIDTH - 1);
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          b_r <= rem_w;
          acc <= one_mod;
          if (n_r == '0) begin
            err    <= 1'b1;
            Result <= '0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
`ifdef MOD_EXP_SKIP_LEAD_EN
            if (e_r == '0) begin
              Result <= one_mod;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              idx   <= IW'(bit_len(64'(e_r)) - 1);
              state <= SQ;
            end
`else
            state <= SQ;
`endif
          end
        end
        SQ: begin
          acc <= rem_w;
          if (e_r[idx]) begin
            state <= MUL;
          end else if (idx == '0) begin
            Result <= rem_w;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        MUL: begin
          acc <= rem_w;
          if (idx == '0) begin
            Result <= rem_w;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            idx   <= idx - 1'b1;
            state <= SQ;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
